// File: rtl/seven_seg_mux.sv
// seven_seg_mux: multiplexed common-anode hex display driver with double-buffered
// loading, leading-zero blanking and PWM brightness.
module seven_seg_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   Anode_Activate,
  output logic [6:0]              LED_out,
  output logic                    dp_out,
  output logic                    frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              led_q, led_d;
  logic                    dp_q, dp_d, tick_q, tick_d;
  logic                    slot_end, wrap, blank, lit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    run;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  // zero_from[i]: nibbles i..top of the display register are all zero
  always_comb begin
    run = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (disp_val_q[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  always_comb begin
    slot_end   = presc_q == P_LAST;
    wrap       = slot_end && idx_q == I_LAST;
    presc_d    = slot_end ? '0 : presc_q + 1'b1;
    idx_d      = slot_end ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    pwm_d      = pwm_q + 1'b1;
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    pending_d  = !wrap && (load || pending_q);
    // a load coinciding with the wrap flows straight through to the display
    disp_val_d = wrap ? pend_val_d : disp_val_q;
    disp_dp_d  = wrap ? pend_dp_d : disp_dp_q;
    nib        = disp_val_q[4*idx_q +: 4];
    blank      = !digit_en[idx_q] || (blank_lz && idx_q != '0 && zero_from[idx_q]);
    lit        = (&brightness) || (pwm_q < brightness);
    anode_d    = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    led_d      = blank ? 7'h7F : seg(nib);
    dp_d       = !(digit_en[idx_q] && disp_dp_q[idx_q]);
    tick_d     = wrap;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pending_q  <= 1'b0;
      anode_q    <= '1;
      led_q      <= 7'h7F;
      dp_q       <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pending_q  <= pending_d;
      anode_q    <= anode_d;
      led_q      <= led_d;
      dp_q       <= dp_d;
      tick_q     <= tick_d;
    end
  end

  assign pending        = pending_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign dp_out         = dp_q;
  assign frame_tick     = tick_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed self-checking bench for seven_seg_mux (4 digits, 4-clock slots).
module tb_seven_seg_mux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        load = 1'b0;
  logic        pending;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;
  logic        dp_out;
  logic        frame_tick;
  int          checks = 0;
  int          errors = 0;
  int          cnt;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
    S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
    S7 = 7'b1111000, SA = 7'b0001000, SX = 7'b1111111;

  seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(2)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness), .load(load),
    .pending(pending), .Anode_Activate(Anode_Activate), .LED_out(LED_out),
    .dp_out(dp_out), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_tick && k < 40);
    chk("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  // checks all 16 cycles of one frame, starting from a frame_tick negedge
  task automatic show_frame(input string tag, input logic [27:0] leds, input logic [3:0] dps);
    logic [3:0] an;
    for (int d = 0; d < 4; d++) begin
      an = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("%s_d%0d_c%0d", tag, d, c), {20'd0, Anode_Activate, LED_out, dp_out},
            {20'd0, an, leds[7*d +: 7], dps[d]});
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, 32'(Anode_Activate), 32'hF);
    chk({tag, "_led"}, 32'(LED_out), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_out), 32'd1);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  task automatic count_lit(input string tag, input logic [1:0] b, input int exp);
    int n;
    brightness = b;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (Anode_Activate != 4'hF) n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    step(3);
    chk_reset("por");
    rst_n = 1'b1;
    pulse_load(16'h5367, 4'h0);
    chk("pending_after_load", 32'(pending), 32'd1);
    wait_frame();
    show_frame("hex5367", {S5, S3, S6, S7}, 4'hF);
    chk("pending_cleared", 32'(pending), 32'd0);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    chk("ticks_per_32", 32'(cnt), 32'd2);

    blank_lz = 1'b1;
    pulse_load(16'h00A0, 4'h0);
    wait_frame();
    show_frame("lz00a0", {SX, SX, SA, S0}, 4'hF);
    pulse_load(16'h0000, 4'h0);
    wait_frame();
    show_frame("lz0000", {SX, SX, SX, S0}, 4'hF);
    blank_lz = 1'b0;

    step(9);
    pulse_load(16'h1111, 4'h0);
    chk("pending_1111", 32'(pending), 32'd1);
    step(2);
    pulse_load(16'h2222, 4'h0);
    chk("pending_2222", 32'(pending), 32'd1);
    wait_frame();
    chk("pending_after_wrap", 32'(pending), 32'd0);
    show_frame("latest2222", {S2, S2, S2, S2}, 4'hF);
    step(15);
    pulse_load(16'h4444, 4'h0);
    chk("wrap_load_tick", 32'(frame_tick), 32'd1);
    chk("wrap_load_pending", 32'(pending), 32'd0);
    show_frame("wrap4444", {S4, S4, S4, S4}, 4'hF);

    count_lit("bright1", 2'd1, 4);
    count_lit("bright0", 2'd0, 0);
    count_lit("bright3", 2'd3, 16);

    digit_en = 4'b1011;
    pulse_load(16'h4321, 4'b0100);
    wait_frame();
    show_frame("den1011", {S4, SX, S2, S1}, 4'hF);
    digit_en = 4'hF;
    show_frame("dp0100", {S4, S3, S2, S1}, 4'b1011);

    step(9);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    step(3);
    chk_reset("mid_rst_hold");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk($sformatf("post_rst_d0_c%0d", c), {20'd0, Anode_Activate, LED_out, dp_out},
          {20'd0, 4'b1110, S0, 1'b1});
    end
    step(1);
    chk("post_rst_d1_anode", 32'(Anode_Activate), 32'(4'b1101));
    chk("post_rst_pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
